// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;

    // Writeback source; also used as the arbiter priority pointer value.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_src_e;

    // One writeback request. 'reg' is a keyword, so the index field is 'idx'.
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb.sv
// Two-input writeback arbiter (ALU vs load) with its priority pointer.
// REGFILE_ARB_RR_EN defined   : round-robin, pointer flips to the loser after each fire.
// REGFILE_ARB_RR_EN undefined : fixed priority, load always wins, no pointer state.
module wb_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic alu_valid_i,
    input  logic ld_valid_i,
    output logic alu_gnt_o,
    output logic ld_gnt_o
);
    import regfile_pkg::*;

`ifdef REGFILE_ARB_RR_EN
    wb_src_e prio_q;

    // Sole requester wins; on contention the pointer names the winner.
    always_comb begin
        ld_gnt_o  = ld_valid_i && (!alu_valid_i || (prio_q == WB_LD));
        alu_gnt_o = alu_valid_i && !ld_gnt_o;
    end

    // After a fire the pointer favours the side that did not fire.
    always_ff @(posedge clk) begin
        if (reset)          prio_q <= WB_ALU;
        else if (alu_gnt_o) prio_q <= WB_LD;
        else if (ld_gnt_o)  prio_q <= WB_ALU;
    end
`else
    // No state in fixed-priority mode; clock and reset are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    // Load always beats ALU; ALU may starve under continuous loads.
    always_comb begin
        ld_gnt_o  = ld_valid_i;
        alu_gnt_o = alu_valid_i && !ld_valid_i;
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: picks one of ALU / load writeback per cycle,
// registers the write command, and keeps the pending-write busy scoreboard.
// Arbitration mode selected by REGFILE_ARB_RR_EN (see wb_rr_arb).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  logic [ADDR_W-1:0]   alu_reg_i,
    input  logic [DATA_W-1:0]   alu_data_i,
    input  logic                ld_valid_i,
    output logic                ld_ready_o,
    input  logic [ADDR_W-1:0]   ld_reg_i,
    input  logic [DATA_W-1:0]   ld_data_i,
    input  logic                busy_set_i,
    input  logic [ADDR_W-1:0]   busy_set_reg_i,
    output logic                rf_write_en_o,
    output logic [ADDR_W-1:0]   rf_write_reg_o,
    output logic [DATA_W-1:0]   rf_write_data_o,
    output logic [NUM_REGS-1:0] busy_o
);

    wb_req_t               alu_req, ld_req, win_req;
    wb_req_t               wr_q;
    logic                  wr_en_q;
    logic                  fire;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    wb_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .alu_valid_i (alu_valid_i),
        .ld_valid_i  (ld_valid_i),
        .alu_gnt_o   (alu_ready_o),
        .ld_gnt_o    (ld_ready_o)
    );

    assign alu_req = '{idx: alu_reg_i, data: alu_data_i};
    assign ld_req  = '{idx: ld_reg_i,  data: ld_data_i};
    assign fire    = alu_ready_o | ld_ready_o;
    assign win_req = ld_ready_o ? ld_req : alu_req;

    // Write command register: load on fire, otherwise drop enable and hold reg/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            wr_en_q <= fire;
            if (fire) wr_q <= win_req;
        end
    end

    // Scoreboard next state: retire clears on the write edge, a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q)    busy_d[wr_q.idx]       = 1'b0;
        if (busy_set_i) busy_d[busy_set_reg_i] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rf_write_en_o   = wr_en_q;
    assign rf_write_reg_o  = wr_q.idx;
    assign rf_write_data_o = wr_q.data;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (either REGFILE_ARB_RR_EN setting).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, busy_set = 1'b0;
    logic        alu_ready, ld_ready;
    logic [3:0]  alu_reg = '0, ld_reg = '0, busy_set_reg = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic        rf_en;
    logic [3:0]  rf_reg;
    logic [31:0] rf_data;
    logic [15:0] busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_en;
    logic [3:0]  m_reg;
    logic [31:0] m_data;
    logic [15:0] m_busy;
    int          m_ptr;   // 0: ALU first, 1: load first

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid_i     (alu_valid),
        .alu_ready_o     (alu_ready),
        .alu_reg_i       (alu_reg),
        .alu_data_i      (alu_data),
        .ld_valid_i      (ld_valid),
        .ld_ready_o      (ld_ready),
        .ld_reg_i        (ld_reg),
        .ld_data_i       (ld_data),
        .busy_set_i      (busy_set),
        .busy_set_reg_i  (busy_set_reg),
        .rf_write_en_o   (rf_en),
        .rf_write_reg_o  (rf_reg),
        .rf_write_data_o (rf_data),
        .busy_o          (busy)
    );

    // Who should win: 0 none, 1 ALU, 2 load
    function automatic int exp_gnt(logic av, logic lv, int p);
`ifdef REGFILE_ARB_RR_EN
        if (av && lv) return (p == 0) ? 1 : 2;
`else
        if (lv) return 2;
`endif
        if (av) return 1;
        if (lv) return 2;
        return 0;
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        int          g;
        logic [15:0] nb;
        g = exp_gnt(alu_valid, ld_valid, m_ptr);
        if (reset) begin
            m_en = 1'b0; m_reg = '0; m_data = '0; m_busy = '0; m_ptr = 0;
        end else begin
            nb = m_busy;
            if (m_en) nb[m_reg] = 1'b0;
            if (busy_set) nb[busy_set_reg] = 1'b1;
            m_busy = nb;
            m_en = (g != 0);
            if (g == 1) begin m_reg = alu_reg; m_data = alu_data; m_ptr = 1; end
            if (g == 2) begin m_reg = ld_reg;  m_data = ld_data;  m_ptr = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; ld_valid = 1'b0; busy_set = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", rf_en); end
        total++; if (rf_reg !== 4'd0) begin bad++; $display("FAIL reset_reg got=%0d want=0", rf_reg); end
        total++; if (rf_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", rf_data); end
        total++; if (busy !== 16'd0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 32'h11;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL single_alu_ready got=%b want=1", alu_ready); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL single_ld_ready got=%b want=0", ld_ready); end
        tick();
        alu_valid = 1'b0;
        total++; if (rf_en !== 1'b1) begin bad++; $display("FAIL single_en got=%b want=1", rf_en); end
        total++; if (rf_reg !== 4'd3) begin bad++; $display("FAIL single_reg got=%0d want=3", rf_reg); end
        total++; if (rf_data !== 32'h11) begin bad++; $display("FAIL single_data got=%h want=11", rf_data); end
        tick();
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL single_en_drop got=%b want=0", rf_en); end
        total++; if (rf_data !== 32'h11) begin bad++; $display("FAIL single_data_hold got=%h want=11", rf_data); end
    endtask

    task automatic test_contention();
        int seq [4];
`ifdef REGFILE_ARB_RR_EN
        seq = '{1, 2, 1, 2};
`else
        seq = '{2, 2, 2, 2};
`endif
        reset = 1'b1; idle_inputs(); tick(); reset = 1'b0;
        alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 32'hA;
        ld_valid  = 1'b1; ld_reg  = 4'd2; ld_data  = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (alu_ready !== (seq[i] == 1)) begin bad++; $display("FAIL contend_alu_ready[%0d] got=%b want=%b", i, alu_ready, seq[i] == 1); end
            total++; if (ld_ready !== (seq[i] == 2)) begin bad++; $display("FAIL contend_ld_ready[%0d] got=%b want=%b", i, ld_ready, seq[i] == 2); end
            tick();
            total++; if (rf_reg !== ((seq[i] == 1) ? 4'd1 : 4'd2)) begin bad++; $display("FAIL contend_reg[%0d] got=%0d", i, rf_reg); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        busy_set = 1'b1; busy_set_reg = 4'd5;
        tick();
        busy_set = 1'b0;
        total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b want=1", busy[5]); end
        tick();
        total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL sb_hold got=%b want=1", busy[5]); end
        alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        total++; if (rf_en !== 1'b1 || busy[5] !== 1'b1) begin bad++; $display("FAIL sb_wr_cycle en=%b busy5=%b want 1,1", rf_en, busy[5]); end
        tick();
        total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b want=0", busy[5]); end
    endtask

    task automatic test_set_clear_same();
        alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        busy_set = 1'b1; busy_set_reg = 4'd7;   // same cycle rf_write_en targets r7
        tick();
        busy_set = 1'b0;
        total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL set_wins got=%b want=1", busy[7]); end
        tick();
        total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL set_wins_hold got=%b want=1", busy[7]); end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 32'hAAAA;
        tick();
        alu_valid = 1'b0;
        ld_valid = 1'b1; ld_reg = 4'd2; ld_data = 32'hBBBB;
        total++; if (rf_data !== 32'hAAAA) begin bad++; $display("FAIL b2b_first got=%h want=aaaa", rf_data); end
        tick();
        ld_valid = 1'b0;
        total++; if (rf_en !== 1'b1 || rf_data !== 32'hBBBB) begin bad++; $display("FAIL b2b_second en=%b data=%h want 1,bbbb", rf_en, rf_data); end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 16; r++) begin
            busy_set = 1'b1; busy_set_reg = r[3:0];
            tick();
        end
        busy_set = 1'b0;
        total++; if (busy !== 16'hFFFF) begin bad++; $display("FAIL rmid_fill got=%h want=ffff", busy); end
        // lone ALU fire moves a round-robin pointer to load-first
        alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 32'h99;
        tick();
        ld_valid = 1'b1; ld_reg = 4'd4; ld_data = 32'h44;
        busy_set = 1'b1; busy_set_reg = 4'd1;
        reset = 1'b1;
        tick();
        reset = 1'b0; busy_set = 1'b0;
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL rmid_en got=%b want=0", rf_en); end
        total++; if (busy !== 16'h0000) begin bad++; $display("FAIL rmid_busy got=%h want=0", busy); end
        #1;
`ifdef REGFILE_ARB_RR_EN
        total++; if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin bad++; $display("FAIL rmid_ptr alu=%b ld=%b want 1,0", alu_ready, ld_ready); end
`else
        total++; if (alu_ready !== 1'b0 || ld_ready !== 1'b1) begin bad++; $display("FAIL rmid_prio alu=%b ld=%b want 0,1", alu_ready, ld_ready); end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 400; c++) begin
            #1;
            g = exp_gnt(alu_valid, ld_valid, m_ptr);
            total++; if (alu_ready !== (g == 1) || ld_ready !== (g == 2)) begin bad++; $display("FAIL rnd_ready[%0d] alu=%b ld=%b want_g=%0d", c, alu_ready, ld_ready, g); end
            tick();
            total++; if (rf_en !== m_en || (m_en && (rf_reg !== m_reg || rf_data !== m_data))) begin bad++; $display("FAIL rnd_wr[%0d] en=%b reg=%0d data=%h want %b %0d %h", c, rf_en, rf_reg, rf_data, m_en, m_reg, m_data); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy[%0d] got=%h want=%h", c, busy, m_busy); end
            total++; if (rf_reg !== m_reg || rf_data !== m_data) begin bad++; $display("FAIL rnd_hold[%0d] reg=%0d data=%h want %0d %h", c, rf_reg, rf_data, m_reg, m_data); end
            // a waiting (non-granted) requester holds its request; others re-roll
            if (reset || !(alu_valid && g != 1)) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_reg = 4'($urandom); alu_data = $urandom;
            end
            if (reset || !(ld_valid && g != 2)) begin
                ld_valid = ($urandom_range(0, 9) < 5);
                ld_reg = 4'($urandom); ld_data = $urandom;
            end
            busy_set = ($urandom_range(0, 9) < 4);
            busy_set_reg = 4'($urandom);
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        m_en = 1'b0; m_reg = '0; m_data = '0; m_busy = '0; m_ptr = 0;
        test_reset();
        test_single_alu();
        test_contention();
        test_scoreboard();
        test_set_clear_same();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
